exchanger_ctrl: RTL and testbench

EXCHANGER_CTRL -- requirements
Module: exchanger_ctrl

---
 rtl/exchanger_ctrl_if.sv | 45 ++++
 rtl/exchanger_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_exchanger_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exchanger_ctrl_if.sv
// Source stream, exchange-buffer and requester signals of exchanger_ctrl, grouped as one bundle.
// master is the controller side; slave is the source, buffer and requesters around it.
interface exchanger_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;

    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          buf_ready;

    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_ready;

    logic          rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_data;

    modport master (
        input  src_valid, src_data, buf_ready, rd_data,
               req0_valid, req0_addr, req1_valid, req1_addr,
        output src_ready, load_valid, load_data, rd_addr,
               req0_ready, req1_ready,
               rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport slave (
        output src_valid, src_data, buf_ready, rd_data,
               req0_valid, req0_addr, req1_valid, req1_addr,
        input  src_ready, load_valid, load_data, rd_addr,
               req0_ready, req1_ready,
               rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/exchanger_ctrl.sv
// Exchange-buffer controller: loads N_ELEM source elements into a write-once buffer, waits for
// the buffer to report ready, then serves fully pipelined round-robin reads to two requesters.
module exchanger_ctrl #(
    parameter int N_ELEM      = 32,
    parameter int DW          = 8,
    parameter int AW          = 5,
    parameter int RDY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    exchanger_ctrl_if.master bus,
    output logic             busy,
    output logic             serving,
    output logic             err
);

    localparam int            TW        = $clog2(RDY_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_BEAT = AW'(N_ELEM - 1);
    localparam logic [TW-1:0] LAST_WAIT = TW'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_RDY,
        S_SERVE,
        S_ERR
    } state_e;

    // One entry per grant in flight: was there a grant, and which requester owns it.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    state_e        state_q, state_d;
    logic [AW-1:0] beat_cnt_q, beat_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    logic          src_ready;
    logic          beat_acc;
    logic          load_valid_q;
    logic [DW-1:0] load_data_q;

    logic          prio_q, prio_d;
    logic          grant0, grant1;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    tag_t          tag_s1_q, tag_s2_q;
    logic          rsp0_valid_q, rsp1_valid_q;
    logic [DW-1:0] rsp0_data_q, rsp1_data_q;

    assign src_ready = (state_q == S_LOAD);
    assign beat_acc  = src_ready && bus.src_valid;

    // ------------------------------------------------------------------ control FSM

    // NOTE: every clocked block uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    beat_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = S_WAIT_RDY;
                        wait_cnt_d = '0;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (bus.buf_ready) begin
                    state_d = S_SERVE;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            // Write-once buffer: SERVE and ERR are left only through reset.
            S_SERVE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ load path

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            load_valid_q <= beat_acc;
            if (beat_acc) begin
                load_data_q <= bus.src_data;
            end
        end
    end

    // ------------------------------------------------------------------ read arbitration

    // prio_q names the requester that wins when both are valid; it flips only on a grant.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        prio_d    = prio_q;
        rd_addr_d = rd_addr_q;
        if (state_q == S_SERVE) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
        if (grant0) begin
            rd_addr_d = bus.req0_addr;
            prio_d    = 1'b1;
        end else if (grant1) begin
            rd_addr_d = bus.req1_addr;
            prio_d    = 1'b0;
        end
    end

    // Tag stages line up with the buffer's two-cycle read latency; the response register is stage three.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q       <= 1'b0;
            rd_addr_q    <= '0;
            tag_s1_q     <= '0;
            tag_s2_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            prio_q         <= prio_d;
            rd_addr_q      <= rd_addr_d;
            tag_s1_q.valid <= grant0 || grant1;
            tag_s1_q.id    <= grant1;
            tag_s2_q       <= tag_s1_q;
            rsp0_valid_q   <= tag_s2_q.valid && !tag_s2_q.id;
            rsp1_valid_q   <= tag_s2_q.valid && tag_s2_q.id;
            if (tag_s2_q.valid && !tag_s2_q.id) begin
                rsp0_data_q <= bus.rd_data;
            end
            if (tag_s2_q.valid && tag_s2_q.id) begin
                rsp1_data_q <= bus.rd_data;
            end
        end
    end

    // ------------------------------------------------------------------ outputs

    assign bus.src_ready  = src_ready;
    assign bus.load_valid = load_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.rd_addr    = rd_addr_d;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_data  = rsp1_data_q;

    assign busy    = (state_q == S_LOAD) || (state_q == S_WAIT_RDY);
    assign serving = (state_q == S_SERVE);
    assign err     = (state_q == S_ERR);

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        !(grant0 && grant1));

    a_grant_in_serve: assert property (@(posedge clk) disable iff (!reset_n)
        (grant0 || grant1) |-> (state_q == S_SERVE));

endmodule

// File: tb/tb_exchanger_ctrl.sv
// Randomised scoreboard bench for exchanger_ctrl with a bench-side exchange buffer and a
// reference model of the element vector and round-robin read service.
module tb_exchanger_ctrl;

    localparam int N_ELEM      = 32;
    localparam int DW          = 8;
    localparam int AW          = 5;
    localparam int RDY_TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy;
    logic serving;
    logic err;

    exchanger_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    exchanger_ctrl #(
        .N_ELEM     (N_ELEM),
        .DW         (DW),
        .AW         (AW),
        .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .serving(serving),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Exchange buffer: stores load beats in order, answers reads two cycles after rd_addr.
    logic [DW-1:0] mem [N_ELEM];
    int            wr_cnt;
    logic [AW-1:0] addr_d1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt      <= 0;
            addr_d1     <= '0;
            bus.rd_data <= '0;
        end else begin
            if (bus.load_valid && wr_cnt < N_ELEM) begin
                mem[wr_cnt] <= bus.load_data;
                wr_cnt      <= wr_cnt + 1;
            end
            addr_d1     <= bus.rd_addr;
            bus.rd_data <= mem[addr_d1];
        end
    end

    // Reference model and scoreboard queues.
    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } rsp_exp_t;

    logic [DW-1:0] ref_elem [N_ELEM];
    logic [DW-1:0] load_q [$];
    rsp_exp_t      rsp_q [$];
    rsp_exp_t      mon_e;
    logic          exp_last;
    logic [AW-1:0] exp_rd_addr;
    bit            exp_serve;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a load beat or a read response.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.load_valid) begin
                check("load_expected", 32'(load_q.size() != 0), 32'd1);
                if (load_q.size() != 0) begin
                    check("load_data", 32'(bus.load_data), 32'(load_q.pop_front()));
                end
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                check("rsp_onehot", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
                check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                    check("rsp_id", 32'(bus.rsp1_valid), 32'(mon_e.id));
                    check("rsp_data", 32'(mon_e.id ? bus.rsp1_data : bus.rsp0_data), 32'(mon_e.data));
                end
            end
            if (rsp_q.size() != 0 && rsp_q[0].due < cyc) begin
                check("rsp_missing", 32'(cyc), 32'(rsp_q[0].due));
                void'(rsp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        start          = 1'b0;
        bus.src_valid  = 1'b0;
        bus.src_data   = '0;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
    endtask

    // Asserts reset shortly after the current point, checks the reset state, releases on a negedge.
    task automatic do_reset();
        check("loads_drained", 32'(load_q.size()), 32'd0);
        #1 reset_n = 1'b0;
        rsp_q.delete();
        load_q.delete();
        idle_inputs();
        bus.buf_ready = 1'b0;
        @(negedge clk); #1;
        check("rst_src_ready", 32'(bus.src_ready), 32'd0);
        check("rst_load", {bus.load_valid, 23'd0, bus.load_data}, 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        check("rst_rsp_data", 32'({bus.rsp0_data, bus.rsp1_data}), 32'd0);
        check("rst_status", 32'({busy, serving, err}), 32'd0);
        check("rst_grants", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        @(negedge clk);
        reset_n     = 1'b1;
        exp_last    = 1'b1;
        exp_rd_addr = '0;
        exp_serve   = 1'b0;
    endtask

    task automatic load_vector(input bit ramp, input bit gapped, output int last_cyc);
        int accepted = 0;
        int budget   = 0;
        last_cyc = cyc;
        for (int i = 0; i < N_ELEM; i++) begin
            ref_elem[i] = ramp ? DW'(i) : DW'($urandom);
        end
        @(negedge clk);
        start = 1'b1;
        #1 check("src_ready_idle", 32'(bus.src_ready), 32'd0);
        while (accepted < N_ELEM && budget < 400) begin
            @(negedge clk);
            start         = 1'b0;
            budget++;
            bus.src_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.src_data  = bus.src_valid ? ref_elem[accepted] : DW'($urandom);
            #1;
            check("src_ready_load", 32'(bus.src_ready), 32'd1);
            check("busy_load", 32'(busy), 32'd1);
            if (bus.src_valid) begin
                load_q.push_back(ref_elem[accepted]);
                accepted++;
                if (accepted == N_ELEM) last_cyc = cyc;
            end
        end
        check("load_beats", 32'(accepted), 32'(N_ELEM));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.src_valid = 1'b1;
            bus.src_data  = DW'($urandom);
            #1 check("src_ready_after_load", 32'(bus.src_ready), 32'd0);
        end
        bus.src_valid = 1'b0;
    endtask

    // buf_ready stays low: err must rise exactly RDY_TIMEOUT cycles after WAIT_RDY entry.
    task automatic expect_timeout(input int last_cyc);
        repeat (20) begin
            @(negedge clk);
            bus.req0_valid = 1'($urandom);
            bus.req0_addr  = AW'($urandom);
            bus.req1_valid = 1'($urandom);
            bus.req1_addr  = AW'($urandom);
            #1;
            check("err_timing", 32'(err), 32'(cyc >= last_cyc + 1 + RDY_TIMEOUT));
            check("busy_wait", 32'(busy), 32'(cyc < last_cyc + 1 + RDY_TIMEOUT));
            check("no_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            check("src_ready_wait", 32'(bus.src_ready), 32'd0);
            check("rd_addr_hold", 32'(bus.rd_addr), 32'(exp_rd_addr));
        end
        idle_inputs();
    endtask

    task automatic enter_serve();
        int waited = 0;
        while (wr_cnt < N_ELEM && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("buffer_filled", 32'(wr_cnt), 32'(N_ELEM));
        @(negedge clk);
        bus.buf_ready = 1'b1;
        @(negedge clk); #1;
        check("serving", 32'(serving), 32'd1);
        check("busy_serve", 32'(busy), 32'd0);
        exp_serve = 1'b1;
    endtask

    task automatic req_cycle(input bit v0, input logic [AW-1:0] a0,
                             input bit v1, input logic [AW-1:0] a1);
        bit       g0;
        bit       g1;
        rsp_exp_t e;
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (exp_serve) begin
            if (v0 && v1) begin
                g0 = exp_last;
                g1 = !exp_last;
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(g0));
        check("req1_ready", 32'(bus.req1_ready), 32'(g1));
        if (g0 || g1) begin
            exp_rd_addr = g1 ? a1 : a0;
            exp_last    = g1;
            e.id        = g1;
            e.data      = ref_elem[exp_rd_addr];
            e.due       = cyc + 3;
            rsp_q.push_back(e);
        end
        check("rd_addr", 32'(bus.rd_addr), 32'(exp_rd_addr));
    endtask

    task automatic random_reads(input int n);
        repeat (n) begin
            req_cycle(1'($urandom_range(0, 1)), AW'($urandom),
                      1'($urandom_range(0, 1)), AW'($urandom));
        end
        req_cycle(1'b0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        int waited = 0;
        while (rsp_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        check("rsp_drained", 32'(rsp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_cyc;
        reset_n = 1'b0;
        idle_inputs();
        bus.buf_ready = 1'b0;

        // Gapped random load, buffer never ready: timeout into ERR, requests ignored.
        do_reset();
        load_vector(1'b0, 1'b1, last_cyc);
        expect_timeout(last_cyc);

        // Ramp load, then serve: alternating burst, lone request, ignored start, random traffic.
        do_reset();
        load_vector(1'b1, 1'b0, last_cyc);
        enter_serve();
        repeat (8) req_cycle(1'b1, AW'($urandom), 1'b1, AW'($urandom));
        req_cycle(1'b0, '0, 1'b0, '0);
        req_cycle(1'b1, AW'(5), 1'b0, AW'($urandom));
        req_cycle(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_ignored_serving", 32'(serving), 32'd1);
        check("start_ignored_src_ready", 32'(bus.src_ready), 32'd0);
        random_reads(150);
        drain();

        // Reset with three reads in flight: nothing may come back, and a fresh load works.
        repeat (3) req_cycle(1'b1, AW'($urandom), 1'b1, AW'($urandom));
        do_reset();
        repeat (8) begin
            @(negedge clk); #1;
            check("idle_after_reset", 32'({busy, serving, err}), 32'd0);
        end
        load_vector(1'b0, 1'b1, last_cyc);
        enter_serve();
        random_reads(100);
        drain();

        check("loads_all_seen", 32'(load_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
